rr_req_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource among N single-bit requesters. Grants are registered, one owner at a time, held while the owner keeps its request high. A hold limit forces release so the resource is shared fairly. It sits between request-generating stimulus/agents and the shared datapath, and carries its own protocol checks as concurrent assertions.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 34 +++
 rtl/rr_req_arbiter.sv | 132 +++++++++++++
 tb/tb_rr_req_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin request arbiter.
// Holds the FSM state encoding and the modulo pointer increment.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_N        = 2;
    localparam int unsigned DEF_MAX_HOLD = 8;

    function automatic int unsigned rr_next(
        input int unsigned ptr,
        input int unsigned n
    );
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping.
// Purely combinational; found is low when no request is set.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] sel
);

    function automatic int unsigned wrap_idx(
        input logic [IW-1:0] p,
        input int unsigned   k
    );
        int unsigned s;
        s = 32'(p) + k;
        if (s >= N) s = s - N;
        return s;
    endfunction

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && req[wrap_idx(ptr, k)]) begin
                found = 1'b1;
                sel   = IW'(wrap_idx(ptr, k));
            end
        end
    end

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter with registered grants, hold limit and dead cycles.
// Define ARB_ASSERT_EN to compile in protocol assertions and coverage.
module rr_req_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned N        = DEF_N,
    parameter  int unsigned MAX_HOLD = DEF_MAX_HOLD,
    localparam int unsigned IW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          busy
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    arb_state_e    state;
    logic [IW-1:0] ptr;
    logic [HW-1:0] hold_cnt;
    logic          found;
    logic [IW-1:0] sel;
    logic          owner_req;
    logic          at_limit;
    logic [IW-1:0] ptr_after;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .sel   (sel)
    );

    assign owner_req = req[gnt_id];
    assign at_limit  = (hold_cnt == HW'(MAX_HOLD));
    assign ptr_after = IW'(rr_next(32'(gnt_id), N));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gnt      <= {{(N-1){1'b0}}, 1'b1} << sel;
                        gnt_id   <= sel;
                        busy     <= 1'b1;
                        hold_cnt <= HW'(1);
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // a dropped request wins over the hold limit
                    if (!owner_req || at_limit) begin
                        gnt    <= '0;
                        gnt_id <= '0;
                        busy   <= 1'b0;
                        ptr    <= ptr_after;
                        state  <= owner_req ? RELEASE : IDLE;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_ASSERT_EN
    localparam int unsigned FAIR_LIM = N * (MAX_HOLD + 2);

    logic                 forced_rel;
    logic [15:0]          run_len;
    logic [N-1:0][15:0]   wait_cnt;

    assign forced_rel = (state == GRANT) && owner_req && at_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_len  <= '0;
            wait_cnt <= '0;
        end else begin
            run_len <= (gnt != '0) ? run_len + 1'b1 : '0;
            for (int i = 0; i < N; i++) begin
                if (req[i] && !gnt[i]) wait_cnt[i] <= wait_cnt[i] + 1'b1;
                else                   wait_cnt[i] <= '0;
            end
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt))
        else $error("%0t onehot gnt=%b req=%b", $time, gnt, req);

    a_first: assert property (@(posedge clk) disable iff (rst)
        (gnt != '0 && $past(gnt) == '0) |-> state == GRANT)
        else $error("%0t first gnt=%b req=%b", $time, gnt, req);

    a_hold: assert property (@(posedge clk) disable iff (rst)
        run_len <= 16'(MAX_HOLD))
        else $error("%0t hold gnt=%b req=%b", $time, gnt, req);

    for (genvar i = 0; i < N; i++) begin : g_chk
        a_req: assert property (@(posedge clk) disable iff (rst)
            gnt[i] |-> $past(req[i]))
            else $error("%0t req gnt=%b req=%b", $time, gnt, req);

        a_fair: assert property (@(posedge clk) disable iff (rst)
            wait_cnt[i] <= 16'(FAIR_LIM))
            else $error("%0t fair gnt=%b req=%b", $time, gnt, req);
    end

    c_forced: cover property (@(posedge clk) disable iff (rst)
        forced_rel);
`endif

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Bench for rr_req_arbiter: directed literals plus random req vs model.
// The model tracks owner, pointer and mandatory idle cycles directly.
module tb_rr_req_arbiter;

    localparam int NR = 2;
    localparam int MH = 4;
    localparam int FAIR = NR * (MH + 2);

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR-1:0] gnt;
    logic [0:0]    gnt_id;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    int m_owner, m_ptr, m_held, m_cool;
    int fw [NR];

    rr_req_arbiter #(
        .N        (NR),
        .MAX_HOLD (MH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Model: owner holds while requesting up to MH cycles; a forced
    // release owes one extra empty cycle before the next pick.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_cool  = 0;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_ptr   = (m_owner + 1) % NR;
                m_owner = -1;
            end else if (m_held == MH) begin
                m_ptr   = (m_owner + 1) % NR;
                m_owner = -1;
                m_cool  = 1;
            end else begin
                m_held++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % NR]) begin
                    m_owner = (m_ptr + k) % NR;
                    m_held  = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [NR-1:0] eg;
        logic [0:0]    ei;
        eg = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
        ei = (m_owner >= 0) ? 1'(m_owner) : 1'b0;
        checks++;
        if (gnt !== eg || gnt_id !== ei || busy !== (m_owner >= 0)) begin
            failures++;
            $display("FAIL model gnt=%b id=%0d busy=%b expected gnt=%b id=%0d",
                     gnt, gnt_id, busy, eg, ei);
        end
        for (int i = 0; i < NR; i++) begin
            if (rst) begin
                fw[i] = 0;
            end else if (gnt[i]) begin
                if (fw[i] > 0) begin
                    checks++;
                    if (fw[i] > FAIR) begin
                        failures++;
                        $display("FAIL fair%0d waited=%0d limit=%0d", i, fw[i], FAIR);
                    end
                end
                fw[i] = 0;
            end else if (req[i]) begin
                fw[i]++;
                if (fw[i] == FAIR + 1) begin
                    checks++;
                    failures++;
                    $display("FAIL starve%0d waited=%0d limit=%0d", i, fw[i], FAIR);
                end
            end else begin
                fw[i] = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [NR-1:0] eg,
                       input logic [0:0] ei);
        @(negedge clk);
        checks++;
        if (gnt !== eg || gnt_id !== ei || busy !== (eg != '0)) begin
            failures++;
            $display("FAIL %s gnt=%b id=%0d busy=%b expected gnt=%b id=%0d",
                     name, gnt, gnt_id, busy, eg, ei);
        end
    endtask

    task automatic do_reset(input logic [NR-1:0] v);
        #1;
        rst = 1'b1;
        req = v;
        chk("rst_pulse", 2'b00, 1'b0);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 2'b11;
        for (int i = 0; i < NR; i++) fw[i] = 0;
        repeat (3) chk("reset", 2'b00, 1'b0);
        #1 rst = 1'b0;
        chk("t1_grant", 2'b01, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_rst gnt=%b busy=%b expected gnt=00 busy=0", gnt, busy);
        end
        chk("t1_rst_hold", 2'b00, 1'b0);
        #1;
        req = 2'b00;
        rst = 1'b0;

        chk("t2_idle", 2'b00, 1'b0);
        #1 req = 2'b01;
        chk("t2_grant", 2'b01, 1'b0);
        #1 req = 2'b00;
        chk("t2_drop", 2'b00, 1'b0);
        #1 req = 2'b11;
        chk("t5_rotate", 2'b10, 1'b1);
        #1 req = 2'b00;
        chk("t5_drop", 2'b00, 1'b0);

        do_reset(2'b11);
        chk("t3_g1", 2'b01, 1'b0);
        chk("t3_g2", 2'b01, 1'b0);
        #1 req = 2'b10;
        chk("t3_dead", 2'b00, 1'b0);
        chk("t3_handover", 2'b10, 1'b1);
        #1 req = 2'b00;
        chk("t3_drop", 2'b00, 1'b0);

        do_reset(2'b01);
        repeat (MH) chk("t4_hold", 2'b01, 1'b0);
        repeat (2) chk("t4_gap", 2'b00, 1'b0);
        chk("t4_regrant", 2'b01, 1'b0);
        #1 req = 2'b00;
        chk("t4_drop", 2'b00, 1'b0);

        do_reset(2'b11);
        repeat (MH) chk("t4b_hold", 2'b01, 1'b0);
        repeat (2) chk("t4b_gap", 2'b00, 1'b0);
        chk("t4b_switch", 2'b10, 1'b1);

        #1 req = 2'b00;
        repeat (2000) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NR; i++)
                if ($urandom_range(3) == 0) req[i] = ~req[i];
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
